// File: rtl/nios_sys_cache_arbiter.sv
// Round-robin arbiter sharing the s2 port of the 512 x 32 cache RAM among the KNN lanes.
// Grant and RAM drive are combinational; read data returns two cycles after the accepting edge.
module nios_sys_cache_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 9,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  input  logic [NREQ*DW/8-1:0] be,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        rdata,
  output logic [NREQ-1:0]      rvalid,
  output logic [AW-1:0]        address2,
  output logic [DW/8-1:0]      byteenable2,
  output logic                 chipselect2,
  output logic                 write2,
  output logic [DW-1:0]        writedata2,
  output logic                 clken2,
  input  logic [DW-1:0]        readdata2
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int BW = DW / 8;

  logic [LW-1:0]   last;
  logic [HW-1:0]   hold;
  logic [NREQ-1:0] rd_pend;
  logic [LW-1:0]   win;
  logic [LW-1:0]   sel;
  logic            win_valid;
  logic            others;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    others    = 1'b0;
    win       = last;
    win_valid = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (LW'(i) != last && req[LW'(i)]) others = 1'b1;
    // A locked owner is preempted only once it has used its hold budget and someone waits.
    if (req[last] && lock[last] && !(hold == HW'(MAX_HOLD) && others))
      win_valid = 1'b1;
    else
      for (int unsigned k = 1; k <= NREQ; k++) begin
        idx = (32'(last) + k) % NREQ;
        if (!win_valid && req[LW'(idx)]) begin
          win       = LW'(idx);
          win_valid = 1'b1;
        end
      end
    if (!reset_n) win_valid = 1'b0;
  end

  // With no winner the data-path muxes fall back to lane 0 so the RAM never sees X.
  always_comb begin
    gnt = '0;
    sel = win_valid ? win : '0;
    if (win_valid) gnt[win] = 1'b1;
    chipselect2 = win_valid;
    write2      = win_valid & we[sel];
    address2    = addr[sel*AW +: AW];
    byteenable2 = be[sel*BW +: BW];
    writedata2  = wdata[sel*DW +: DW];
    clken2      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last    <= LW'(NREQ - 1);
      hold    <= '0;
      rd_pend <= '0;
      rvalid  <= '0;
      rdata   <= '0;
    end else begin
      rvalid <= rd_pend;
      if (|rd_pend) rdata <= readdata2;
      if (win_valid) begin
        last    <= win;
        hold    <= (win == last && hold < HW'(MAX_HOLD)) ? hold + 1'b1 : HW'(1);
        rd_pend <= we[win] ? '0 : gnt;
      end else begin
        rd_pend <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nios_sys_cache_arbiter.sv
// Bench for nios_sys_cache_arbiter: behavioural RAM plus a rule-level model of grant order,
// memory contents and read return, checked cycle by cycle.
module tb_nios_sys_cache_arbiter;
  localparam int NREQ     = 4;
  localparam int AW       = 9;
  localparam int DW       = 32;
  localparam int BW       = DW / 8;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [NREQ-1:0]   req, lock, we, gnt, rvalid;
  logic [AW-1:0]     l_addr  [NREQ];
  logic [DW-1:0]     l_wdata [NREQ];
  logic [BW-1:0]     l_be    [NREQ];
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ*BW-1:0] be;
  logic [DW-1:0]     rdata, writedata2, readdata2;
  logic [AW-1:0]     address2;
  logic [BW-1:0]     byteenable2;
  logic              chipselect2, write2, clken2;

  always_comb begin
    addr  = '0;
    wdata = '0;
    be    = '0;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW]  = l_addr[i];
      wdata[i*DW +: DW] = l_wdata[i];
      be[i*BW +: BW]    = l_be[i];
    end
  end

  nios_sys_cache_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
    .write2(write2), .writedata2(writedata2), .clken2(clken2), .readdata2(readdata2)
  );

  // RAM s2 port: address registered at the edge, data out unregistered.
  logic [DW-1:0] ram [512];
  logic [AW-1:0] ram_aq = '0;
  assign readdata2 = ram[ram_aq];
  always @(posedge clk)
    if (chipselect2 && clken2) begin
      ram_aq <= address2;
      if (write2)
        for (int b = 0; b < BW; b++)
          if (byteenable2[b]) ram[address2][b*8 +: 8] <= writedata2[b*8 +: 8];
    end

  int checks = 0;
  int errors = 0;

  int            m_last, m_hold, m_pend;
  logic [DW-1:0] m_pdata, m_rdata;
  logic [NREQ-1:0] m_rvalid;
  logic [DW-1:0] m_mem [512];

  logic [NREQ-1:0] exp_gnt, obs_gnt, exp_rvalid, obs_rvalid;
  logic [DW-1:0]   exp_rdata, obs_rdata;
  logic            exp_cs, obs_cs, exp_w2, obs_w2;
  logic [AW-1:0]   exp_a2, obs_a2;

  function automatic int lane_of(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic set_cmd(input int l, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] b);
    req[l] = 1'b1; we[l] = w; l_addr[l] = a; l_wdata[l] = d; l_be[l] = b;
  endtask

  // One clock cycle: predict the winner from the arbitration rules, sample the DUT,
  // advance the model across the edge, then sample the registered outputs.
  task automatic tick();
    int w, others;
    #1;
    w = -1;
    if (reset_n) begin
      others = 0;
      for (int i = 0; i < NREQ; i++) if (req[i] && i != m_last) others++;
      if (req[m_last] && lock[m_last] && !(m_hold == MAX_HOLD && others > 0)) w = m_last;
      else
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
    end
    exp_gnt = (w >= 0) ? NREQ'(1 << w) : '0;
    exp_cs  = (w >= 0);
    exp_w2  = (w >= 0) && we[w];
    exp_a2  = (w >= 0) ? l_addr[w] : '0;
    obs_gnt = gnt; obs_cs = chipselect2; obs_w2 = write2; obs_a2 = address2;
    if (!reset_n) begin
      m_last = NREQ - 1; m_hold = 0; m_pend = -1; m_rvalid = '0; m_rdata = '0;
    end else begin
      m_rvalid = (m_pend >= 0) ? NREQ'(1 << m_pend) : '0;
      if (m_pend >= 0) m_rdata = m_pdata;
      m_pend = -1;
      if (w >= 0) begin
        if (we[w]) begin
          for (int b = 0; b < BW; b++)
            if (l_be[w][b]) m_mem[l_addr[w]][b*8 +: 8] = l_wdata[w][b*8 +: 8];
        end else begin
          m_pend  = w;
          m_pdata = m_mem[l_addr[w]];
        end
        m_hold = (w == m_last) ? ((m_hold < MAX_HOLD) ? m_hold + 1 : 1) : 1;
        m_last = w;
      end
    end
    exp_rvalid = m_rvalid;
    exp_rdata  = m_rdata;
    @(posedge clk);
    #1;
    obs_rvalid = rvalid;
    obs_rdata  = rdata;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '1; lock = '0; we = '0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (obs_gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", obs_gnt); end
      checks++; if (obs_cs !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b exp=0", obs_cs); end
      checks++; if (obs_rvalid !== '0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0000", obs_rvalid); end
      checks++; if (obs_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", obs_rdata); end
    end
    reset_n = 1'b1; req = '0;
  endtask

  // Every lane writes continuously; lane l's j-th grant writes address l+4j, filling 0..15.
  task automatic test_round_robin();
    int cnt [NREQ];
    int g;
    for (int l = 0; l < NREQ; l++) begin
      cnt[l] = 1;
      set_cmd(l, 1'b1, AW'(l), DW'($urandom), '1);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, obs_gnt, exp_gnt); end
      checks++; if (obs_gnt !== NREQ'(1 << (k % NREQ))) begin errors++; $display("FAIL rr_order k=%0d got=%b exp=%b", k, obs_gnt, NREQ'(1 << (k % NREQ))); end
      checks++; if (obs_rvalid !== '0) begin errors++; $display("FAIL rr_rvalid k=%0d got=%b exp=0000", k, obs_rvalid); end
      g = lane_of(obs_gnt);
      if (g >= 0) begin
        if (cnt[g] < 4) begin set_cmd(g, 1'b1, AW'(g + 4 * cnt[g]), DW'($urandom), '1); cnt[g]++; end
        else req[g] = 1'b0;
      end
    end
    req = '0;
  endtask

  task automatic test_write_read();
    set_cmd(2, 1'b1, 9'h1A5, 32'hDEADBEEF, 4'b1111);
    tick();
    checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL wr_gnt got=%b exp=0100", obs_gnt); end
    set_cmd(2, 1'b0, 9'h1A5, '0, '0);
    tick();
    checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL rd_gnt got=%b exp=0100", obs_gnt); end
    checks++; if (obs_rvalid !== '0) begin errors++; $display("FAIL rd_early got=%b exp=0000", obs_rvalid); end
    req = '0;
    tick();
    checks++; if (obs_rvalid !== 4'b0100) begin errors++; $display("FAIL rd_rvalid got=%b exp=0100", obs_rvalid); end
    checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", obs_rdata); end
    checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rd_model got=%h exp=%h", obs_rdata, exp_rdata); end
  endtask

  task automatic test_byte_enable();
    set_cmd(0, 1'b1, 9'h000, 32'h11223344, 4'b1111); tick();
    set_cmd(0, 1'b1, 9'h000, 32'hAABBCCDD, 4'b0101); tick();
    set_cmd(0, 1'b0, 9'h000, '0, '0); tick();
    req = '0;
    tick();
    checks++; if (obs_rvalid !== 4'b0001) begin errors++; $display("FAIL be_rvalid got=%b exp=0001", obs_rvalid); end
    checks++; if (obs_rdata !== 32'h11BB33DD) begin errors++; $display("FAIL be_data got=%h exp=11bb33dd", obs_rdata); end
  endtask

  // Lane 1 locked, lane 3 waiting: 8 grants to lane 1, one to lane 3, then lane 1 again;
  // afterwards lane 3 idles and lane 1 keeps ownership.
  task automatic test_lock();
    logic [NREQ-1:0] want;
    lock = 4'b0010;
    set_cmd(1, 1'b0, AW'($urandom_range(15)), '0, '0);
    set_cmd(3, 1'b0, AW'($urandom_range(15)), '0, '0);
    for (int k = 0; k < 30; k++) begin
      tick();
      want = (k == 8) ? 4'b1000 : 4'b0010;
      checks++; if (obs_gnt !== want) begin errors++; $display("FAIL lock_seq k=%0d got=%b exp=%b", k, obs_gnt, want); end
      checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL lock_gnt k=%0d got=%b exp=%b", k, obs_gnt, exp_gnt); end
      checks++; if (obs_rvalid !== exp_rvalid || obs_rdata !== exp_rdata) begin
        errors++; $display("FAIL lock_rd k=%0d got=%b/%h exp=%b/%h", k, obs_rvalid, obs_rdata, exp_rvalid, exp_rdata); end
      if (obs_gnt[3]) req[3] = 1'b0;
      if (obs_gnt[1]) l_addr[1] = AW'($urandom_range(15));
    end
    req = '0; lock = '0;
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 4; j++) begin
      set_cmd((j == 3) ? 3 : 0, 1'b1, AW'(j), DW'(32'hA0 + j), '1);
      tick();
      req = '0;
    end
    for (int l = 0; l < NREQ; l++) set_cmd(l, 1'b0, AW'(l), '0, '0);
    for (int t = 0; t < 6; t++) begin
      tick();
      if (t < 4) begin
        checks++; if (obs_gnt !== NREQ'(1 << t)) begin errors++; $display("FAIL b2b_gnt t=%0d got=%b exp=%b", t, obs_gnt, NREQ'(1 << t)); end
      end
      req &= ~obs_gnt;
      if (t >= 1 && t <= 4) begin
        checks++; if (obs_rvalid !== NREQ'(1 << (t - 1))) begin errors++; $display("FAIL b2b_rvalid t=%0d got=%b exp=%b", t, obs_rvalid, NREQ'(1 << (t - 1))); end
        checks++; if (obs_rdata !== DW'(32'hA0 + t - 1)) begin errors++; $display("FAIL b2b_data t=%0d got=%h exp=%h", t, obs_rdata, DW'(32'hA0 + t - 1)); end
      end else begin
        checks++; if (obs_rvalid !== '0) begin errors++; $display("FAIL b2b_idle t=%0d got=%b exp=0000", t, obs_rvalid); end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_cmd(2, 1'b0, 9'h005, '0, '0);
    tick();
    checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL rmid_gnt got=%b exp=0100", obs_gnt); end
    req = '0; reset_n = 1'b0;
    tick();
    checks++; if (obs_rvalid !== '0) begin errors++; $display("FAIL rmid_rvalid got=%b exp=0000", obs_rvalid); end
    checks++; if (obs_rdata !== '0) begin errors++; $display("FAIL rmid_rdata got=%h exp=0", obs_rdata); end
    reset_n = 1'b1;
    for (int l = 0; l < NREQ; l++) set_cmd(l, 1'b0, AW'(l), '0, '0);
    for (int t = 0; t < 6; t++) begin
      tick();
      if (t == 0) begin
        checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL rmid_first got=%b exp=0001", obs_gnt); end
        checks++; if (obs_rvalid !== '0) begin errors++; $display("FAIL rmid_stale got=%b exp=0000", obs_rvalid); end
      end
      checks++; if (obs_gnt !== exp_gnt || obs_rvalid !== exp_rvalid || obs_rdata !== exp_rdata) begin
        errors++; $display("FAIL rmid_model t=%0d got=%b/%b/%h exp=%b/%b/%h", t, obs_gnt, obs_rvalid, obs_rdata, exp_gnt, exp_rvalid, exp_rdata); end
      req &= ~obs_gnt;
    end
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 400; n++) begin
      for (int l = 0; l < NREQ; l++) begin
        lock[l] = ($urandom_range(7) != 0);
        if (!req[l] && $urandom_range(7) != 0)
          set_cmd(l, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom), BW'($urandom_range(15)));
      end
      tick();
      checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt n=%0d got=%b exp=%b", n, obs_gnt, exp_gnt); end
      checks++; if (obs_cs !== exp_cs || obs_w2 !== exp_w2) begin errors++; $display("FAIL rnd_ctl n=%0d got=%b%b exp=%b%b", n, obs_cs, obs_w2, exp_cs, exp_w2); end
      if (exp_cs) begin
        checks++; if (obs_a2 !== exp_a2) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, obs_a2, exp_a2); end
      end
      checks++; if (obs_rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid n=%0d got=%b exp=%b", n, obs_rvalid, exp_rvalid); end
      checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, obs_rdata, exp_rdata); end
      g = lane_of(obs_gnt);
      if (g >= 0) req[g] = 1'b0;
    end
    req = '0; lock = '0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (obs_rvalid !== exp_rvalid || obs_rdata !== exp_rdata) begin
        errors++; $display("FAIL rnd_drain n=%0d got=%b/%h exp=%b/%h", n, obs_rvalid, obs_rdata, exp_rvalid, exp_rdata); end
    end
  endtask

  initial begin
    reset_n = 1'b0; req = '0; lock = '0; we = '0;
    for (int l = 0; l < NREQ; l++) begin l_addr[l] = '0; l_wdata[l] = '0; l_be[l] = '0; end
    for (int a = 0; a < 512; a++) m_mem[a] = '0;
    m_last = NREQ - 1; m_hold = 0; m_pend = -1; m_pdata = '0; m_rdata = '0; m_rvalid = '0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_byte_enable();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_sys_cache_arbiter.md
# nios_sys_cache_arbiter

Round-robin arbiter that shares the second (s2) port of the 512 x 32 dual-port cache RAM between the KNN processing lanes. Port s1 of the RAM stays with the Nios master. Each lane issues single-word reads and byte-enabled writes. The arbiter grants one lane per cycle, drives the RAM port combinationally from the winner, and returns read data to the issuing lane with fixed latency. A per-lane lock input gives a lane bounded back-to-back ownership for its distance-update sequences.

## Interface

Parameters:
- NREQ, 4, number of requesting lanes (2..8)
- AW, 9, RAM word-address width
- DW, 32, data width; byte-enable width is DW/8
- MAX_HOLD, 8, maximum consecutive grants to a locked lane while other lanes are waiting

Ports:
- clk  in  1  single clock for the arbiter and the RAM s2 port
- reset_n  in  1  synchronous, active-low reset
- req  in  NREQ  per-lane request; held until gnt
- lock  in  NREQ  per-lane request to keep ownership on the next cycle
- we  in  NREQ  per-lane write (1) / read (0)
- addr  in  NREQ*AW  per-lane word address; lane i uses slice [i*AW +: AW]
- wdata  in  NREQ*DW  per-lane write data
- be  in  NREQ*DW/8  per-lane byte enables
- gnt  out  NREQ  one-hot combinational grant; the command is accepted on the clock edge at which gnt is high
- rdata  out  DW  registered read data, shared by all lanes
- rvalid  out  NREQ  one-hot, one-cycle read-return strobe
- address2  out  AW  to RAM
- byteenable2  out  DW/8  to RAM
- chipselect2  out  1  to RAM
- write2  out  1  to RAM
- writedata2  out  DW  to RAM
- clken2  out  1  to RAM; tied to 1
- readdata2  in  DW  from RAM; unregistered output, valid the cycle after the address is presented

## Operation

- State registers:
  - last: index of the last granted lane.
  - hold: consecutive-grant count of that lane, 0..MAX_HOLD.
  - rd_pend: NREQ-bit one-hot marking the read captured next.
  - rvalid, rdata.
- Winner selection, each cycle:
  1. Keep rule: if req[last] and lock[last], the winner is last. Exceptions: when hold == MAX_HOLD and some other req is high, the keep rule is skipped.
  2. Otherwise, round-robin: the first lane with req high, searching last+1, last+2, ... modulo NREQ. The search wraps, so lane last itself is checked last.
  3. If no req is high, there is no winner and gnt = 0.
- With a winner w:
  - gnt[w] = 1.
  - chipselect2 = 1.
  - address2, byteenable2, writedata2 and write2 are muxed from lane w.
- With no winner, chipselect2 = 0 and write2 = 0. The other RAM outputs are don't-care but are driven from lane 0, so they never go to X.
- On a clock edge where a winner exists:
  - last <= w.
  - hold update:
    - hold <= hold+1 when w == last and hold < MAX_HOLD.
    - hold <= 1 when w == last, hold == MAX_HOLD and no other lane is waiting (counter restarts).
    - hold <= 1 when w != last.
  - rd_pend <= onehot(w) & ~we[w].
- On an idle edge:
  - last and hold are unchanged, so a locked lane may resume as owner.
  - rd_pend <= 0.
- Read return, every edge:
  - rdata <= readdata2 when rd_pend != 0; otherwise rdata holds its value.
  - rvalid <= rd_pend.
- Writes produce no rvalid.
- The arbiter does not order s2 accesses against s1. A same-address mixed-port collision is undefined at the RAM, and the software protocol prevents it.
- Reset (reset_n low at an edge):
  - last <= NREQ-1, so lane 0 has top priority afterwards.
  - hold <= 0.
  - rd_pend <= 0, rvalid <= 0, rdata <= 0.
  - While reset_n is low, gnt = 0 and chipselect2 = 0.
- Reset mid-operation: reads that are in flight are discarded and no rvalid is issued for them.

## Timing

- Cycle T: lane i request wins; gnt[i] is high and RAM s2 is driven.
- Edge ending T: RAM registers the address; arbiter updates last, hold and rd_pend.
- Cycle T+1: readdata2 is valid; arbiter captures it at the edge ending T+1.
- Cycle T+2: rvalid[i] = 1 and rdata holds the word. Read latency is 2 cycles from the accepting edge.
- Throughput: one access per cycle. Back-to-back reads from any lanes return in issue order, one per cycle.
- Write in cycle T: the RAM contents are updated at the edge ending T. A read of the same address granted in T+1 returns the new data.
- gnt depends combinationally on req, lock, last and hold. It does not depend on addr or wdata.
- Requesters must hold their command stable while req is high and gnt is low.

## Test plan

- Reset, then all four req high continuously with lock = 0 -> grants go 0,1,2,3,0,... one per cycle, with no lane skipped or repeated.
- Lane 2 writes 0xDEADBEEF to address 0x1A5 with be = 4'b1111, then lane 2 reads 0x1A5 on the next cycle -> rvalid[2] two cycles after the read grant, with rdata = 0xDEADBEEF.
- Byte-enable check: write 0x11223344 to address 0x000 with be = 4'b1111, then write 0xAABBCCDD with be = 4'b0101, then read 0x000 -> rdata = 0x11BB33DD.
- Lane 1 holds req and lock high while lane 3 requests from cycle 0 -> lane 1 gets 8 consecutive grants, then lane 3 gets one grant, then lane 1 resumes. With lane 3 idle instead, lane 1 keeps ownership indefinitely.
- Back-to-back reads from lanes 0, 1, 2, 3 to addresses 0..3 preloaded with 0xA0..0xA3 -> rvalid goes 0001, 0010, 0100, 1000 on consecutive cycles, carrying matching data.
- reset_n is driven low in the cycle after a read grant -> no rvalid is issued, rdata = 0, and the first post-reset grant goes to lane 0 when all lanes request.
